// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-ported integer register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback or flush,
// with the writeback releasing an operand in the same cycle it is bypassed.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     busy_set_en,
    input  logic [ADDR_W-1:0]        busy_set_addr,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] wr_hit;

    // Registers receiving a writeback this cycle; x0 never counts.
    always_comb begin
        // NOTE: every bit gets a default before the loop, so no latch is inferred.
        wr_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                wr_hit[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        wr_hit[0] = 1'b0;
    end

    // Clear, then set (new producer wins), then flush overrides everything.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (busy_set_en) begin
            busy_d[busy_set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_busy[r] = busy_q[rd_addr[r*ADDR_W +: ADDR_W]]
                       & ~wr_hit[rd_addr[r*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-to-read bypass and busy scoreboard.
// Optional debug read port enabled by defining REGFILE_MP_DEBUG_PORT_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     busy_set_en,
    input  logic [ADDR_W-1:0]        busy_set_addr,
`ifdef REGFILE_MP_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
`endif
    input  logic                     flush
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_addr_arr [NUM_WR];
    logic [DATA_W-1:0] wr_data_arr [NUM_WR];
    logic [ADDR_W-1:0] rd_addr_arr [NUM_RD];
    logic [DATA_W-1:0] rd_data_arr [NUM_RD];
    logic [NUM_WR-1:0] wr_live;

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_addr_arr[w] = wr_addr[w*ADDR_W +: ADDR_W];
            wr_data_arr[w] = wr_data[w*DATA_W +: DATA_W];
            wr_live[w]     = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != '0);
        end
        for (int r = 0; r < NUM_RD; r++) begin
            rd_addr_arr[r] = rd_addr[r*ADDR_W +: ADDR_W];
        end
    end

    // Entry 0 is reset and never written, so it reads as zero everywhere.
    // Later ports are assigned last, so the highest index wins a conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset because reads must return 0 straight out of reset.
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_live[w]) begin
                    mem[wr_addr_arr[w]] <= wr_data_arr[w];
                end
            end
        end
    end

    // Bypass: the highest-index live write to the read address overrides storage.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data_arr[r] = mem[rd_addr_arr[r]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_live[w] && (wr_addr_arr[w] == rd_addr_arr[r])) begin
                    rd_data_arr[r] = wr_data_arr[w];
                end
            end
            if (rst) begin
                rd_data_arr[r] = '0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r*DATA_W +: DATA_W] = rd_data_arr[r];
        end
    end

`ifdef REGFILE_MP_DEBUG_PORT_EN
    assign dbg_data = mem[dbg_addr];
`endif

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .flush         (flush),
        .rd_addr       (rd_addr),
        .rd_busy       (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default-parameter instance (directed and
// random traffic) and a NUM_RD=4/NUM_WR=1/ADDR_W=4/DATA_W=64 instance (random).
module tb_regfile_mp;

    localparam int AW_A = 5, DW_A = 32, NR_A = 2, NW_A = 2;
    localparam int AW_B = 4, DW_B = 64, NR_B = 4, NW_B = 1;
    localparam int RAND_CYCLES = 10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NW_A-1:0]      wr_en_a;
    logic [NW_A*AW_A-1:0] wr_addr_a;
    logic [NW_A*DW_A-1:0] wr_data_a;
    logic [NR_A*AW_A-1:0] rd_addr_a;
    logic [NR_A*DW_A-1:0] rd_data_a;
    logic [NR_A-1:0]      rd_busy_a;
    logic                 bs_en_a;
    logic [AW_A-1:0]      bs_addr_a;
    logic                 flush_a;

    logic [NW_B-1:0]      wr_en_b;
    logic [NW_B*AW_B-1:0] wr_addr_b;
    logic [NW_B*DW_B-1:0] wr_data_b;
    logic [NR_B*AW_B-1:0] rd_addr_b;
    logic [NR_B*DW_B-1:0] rd_data_b;
    logic [NR_B-1:0]      rd_busy_b;
    logic                 bs_en_b;
    logic [AW_B-1:0]      bs_addr_b;
    logic                 flush_b;

`ifdef REGFILE_MP_DEBUG_PORT_EN
    logic [AW_A-1:0] dbg_addr_a;
    logic [DW_A-1:0] dbg_data_a;
    logic [AW_B-1:0] dbg_addr_b;
    logic [DW_B-1:0] dbg_data_b;
`endif

    regfile_mp #(.DATA_W(DW_A), .ADDR_W(AW_A), .NUM_RD(NR_A), .NUM_WR(NW_A)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en_a),
        .wr_addr       (wr_addr_a),
        .wr_data       (wr_data_a),
        .rd_addr       (rd_addr_a),
        .rd_data       (rd_data_a),
        .rd_busy       (rd_busy_a),
        .busy_set_en   (bs_en_a),
        .busy_set_addr (bs_addr_a),
`ifdef REGFILE_MP_DEBUG_PORT_EN
        .dbg_addr      (dbg_addr_a),
        .dbg_data      (dbg_data_a),
`endif
        .flush         (flush_a)
    );

    regfile_mp #(.DATA_W(DW_B), .ADDR_W(AW_B), .NUM_RD(NR_B), .NUM_WR(NW_B)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en_b),
        .wr_addr       (wr_addr_b),
        .wr_data       (wr_data_b),
        .rd_addr       (rd_addr_b),
        .rd_data       (rd_data_b),
        .rd_busy       (rd_busy_b),
        .busy_set_en   (bs_en_b),
        .busy_set_addr (bs_addr_b),
`ifdef REGFILE_MP_DEBUG_PORT_EN
        .dbg_addr      (dbg_addr_b),
        .dbg_data      (dbg_data_b),
`endif
        .flush         (flush_b)
    );

    // Expected-response queue: kind 0 = rd_data, 1 = rd_busy, 2 = dbg_data.
    typedef struct {
        int          inst;
        int          kind;
        int          idx;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: architectural register contents and busy flags per instance.
    logic [63:0] m_regs [2][32];
    bit          m_busy [2][32];

    function automatic int n_wr(int i);  return (i == 0) ? NW_A : NW_B; endfunction
    function automatic int n_rd(int i);  return (i == 0) ? NR_A : NR_B; endfunction
    function automatic int depth(int i); return (i == 0) ? 32 : 16;     endfunction

    function automatic bit wen(int i, int w);
        return (i == 0) ? wr_en_a[w] : wr_en_b[w];
    endfunction
    function automatic int waddr(int i, int w);
        return (i == 0) ? int'(wr_addr_a[w*AW_A +: AW_A]) : int'(wr_addr_b[w*AW_B +: AW_B]);
    endfunction
    function automatic logic [63:0] wdata(int i, int w);
        return (i == 0) ? 64'(wr_data_a[w*DW_A +: DW_A]) : wr_data_b[w*DW_B +: DW_B];
    endfunction
    function automatic int raddr(int i, int r);
        return (i == 0) ? int'(rd_addr_a[r*AW_A +: AW_A]) : int'(rd_addr_b[r*AW_B +: AW_B]);
    endfunction

    // Value seen by a reader: latest enabled write to that register this cycle, else stored.
    function automatic logic [63:0] m_read(int i, int a);
        logic [63:0] v;
        if (rst || a == 0) return 64'd0;
        v = m_regs[i][a];
        for (int w = 0; w < n_wr(i); w++)
            if (wen(i, w) && waddr(i, w) == a) v = wdata(i, w);
        return v;
    endfunction

    function automatic bit m_written(int i, int a);
        bit hit;
        hit = 1'b0;
        for (int w = 0; w < n_wr(i); w++)
            if (wen(i, w) && waddr(i, w) == a && a != 0) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit m_pending(int i, int a);
        if (rst) return 1'b0;
        return m_busy[i][a] && !m_written(i, a);
    endfunction

    task automatic m_commit(int i);
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                m_regs[i][a] = 64'd0;
                m_busy[i][a] = 1'b0;
            end
        end else begin
            for (int w = 0; w < n_wr(i); w++) begin
                if (wen(i, w) && waddr(i, w) != 0) begin
                    m_regs[i][waddr(i, w)] = wdata(i, w);
                    m_busy[i][waddr(i, w)] = 1'b0;
                end
            end
            if ((i == 0) ? flush_a : flush_b) begin
                for (int a = 0; a < 32; a++) m_busy[i][a] = 1'b0;
            end else if ((i == 0) ? bs_en_a : bs_en_b) begin
                if (i == 0 && bs_addr_a != '0) m_busy[0][int'(bs_addr_a)] = 1'b1;
                if (i == 1 && bs_addr_b != '0) m_busy[1][int'(bs_addr_b)] = 1'b1;
            end
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic push(int inst, int kind, int idx, logic [63:0] exp);
        exp_t e;
        e.inst = inst;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic push_model();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < n_rd(i); r++) begin
                push(i, 0, r, m_read(i, raddr(i, r)));
                push(i, 1, r, 64'(m_pending(i, raddr(i, r))));
            end
        end
`ifdef REGFILE_MP_DEBUG_PORT_EN
        push(0, 2, 0, (rst || dbg_addr_a == '0) ? 64'd0 : m_regs[0][int'(dbg_addr_a)]);
        push(1, 2, 0, (rst || dbg_addr_b == '0) ? 64'd0 : m_regs[1][int'(dbg_addr_b)]);
`endif
    endtask

    function automatic logic [63:0] actual(exp_t e);
        logic [63:0] v;
        v = 'x;
        if (e.inst == 0) begin
            case (e.kind)
                0: v = 64'(rd_data_a[e.idx*DW_A +: DW_A]);
                1: v = 64'(rd_busy_a[e.idx]);
`ifdef REGFILE_MP_DEBUG_PORT_EN
                2: v = 64'(dbg_data_a);
`endif
                default: v = 'x;
            endcase
        end else begin
            case (e.kind)
                0: v = rd_data_b[e.idx*DW_B +: DW_B];
                1: v = 64'(rd_busy_b[e.idx]);
`ifdef REGFILE_MP_DEBUG_PORT_EN
                2: v = dbg_data_b;
`endif
                default: v = 'x;
            endcase
        end
        return v;
    endfunction

    function automatic string kind_name(int k);
        return (k == 0) ? "rd_data" : (k == 1) ? "rd_busy" : "dbg_data";
    endfunction

    // Monitor: outputs are combinational, so every queued expectation is checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s inst%0d port%0d", kind_name(e.kind), e.inst, e.idx),
                      actual(e), e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    function automatic int pick_a();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9);
    endfunction

    task automatic idle_a();
        wr_en_a   = '0;
        wr_addr_a = '0;
        wr_data_a = '0;
        rd_addr_a = '0;
        bs_en_a   = 1'b0;
        bs_addr_a = '0;
        flush_a   = 1'b0;
`ifdef REGFILE_MP_DEBUG_PORT_EN
        dbg_addr_a = AW_A'($urandom_range(0, 31));
`endif
    endtask

    task automatic rand_a();
        wr_en_a = NW_A'($urandom);
        for (int w = 0; w < NW_A; w++) begin
            wr_addr_a[w*AW_A +: AW_A] = AW_A'(pick_a());
            wr_data_a[w*DW_A +: DW_A] = $urandom;
        end
        for (int r = 0; r < NR_A; r++) rd_addr_a[r*AW_A +: AW_A] = AW_A'(pick_a());
        bs_en_a   = ($urandom_range(0, 2) == 0);
        bs_addr_a = AW_A'(pick_a());
        flush_a   = ($urandom_range(0, 40) == 0);
`ifdef REGFILE_MP_DEBUG_PORT_EN
        dbg_addr_a = AW_A'(pick_a());
`endif
    endtask

    task automatic rand_b();
        wr_en_b = NW_B'($urandom);
        wr_addr_b = AW_B'($urandom_range(0, 15));
        wr_data_b = {$urandom, $urandom};
        for (int r = 0; r < NR_B; r++) rd_addr_b[r*AW_B +: AW_B] = AW_B'($urandom_range(0, 15));
        bs_en_b   = ($urandom_range(0, 2) == 0);
        bs_addr_b = AW_B'($urandom_range(0, 15));
        flush_b   = ($urandom_range(0, 40) == 0);
`ifdef REGFILE_MP_DEBUG_PORT_EN
        dbg_addr_b = AW_B'($urandom_range(0, 15));
`endif
    endtask

    // One cycle: randomize B, queue model expectations, cross the edge, update model.
    task automatic step();
        rand_b();
        push_model();
        @(posedge clk);
        m_commit(0);
        m_commit(1);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_a();
        rand_b();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++) begin
                m_regs[i][a] = 64'd0;
                m_busy[i][a] = 1'b0;
            end
        @(posedge clk);
        #1;

        // Reset state with live traffic presented: everything reads 0 and not busy.
        wr_en_a = 2'b11;
        wr_addr_a = {AW_A'(2), AW_A'(2)};
        wr_data_a = {32'h1111_2222, 32'h3333_4444};
        rd_addr_a = {AW_A'(2), AW_A'(2)};
        push(0, 0, 0, 64'd0);
        push(0, 1, 1, 64'd0);
        step();
        rst = 1'b0;

        // Bypass before and after the edge.
        idle_a();
        wr_en_a = 2'b01;
        wr_addr_a[0 +: AW_A] = AW_A'(7);
        wr_data_a[0 +: DW_A] = 32'h1234;
        rd_addr_a[AW_A +: AW_A] = AW_A'(7);
        #1;
        check("bypass x7 pre-edge", 64'(rd_data_a[AW_A*0 + DW_A +: DW_A]), 64'h1234);
        push(0, 0, 1, 64'h1234);
        step();
        idle_a();
        rd_addr_a[AW_A +: AW_A] = AW_A'(7);
        push(0, 0, 1, 64'h1234);
        step();

        // x0 protection on both ports, including busy_set of x0.
        idle_a();
        wr_en_a = 2'b11;
        wr_data_a = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bs_en_a = 1'b1;
        push(0, 0, 0, 64'd0);
        push(0, 0, 1, 64'd0);
        step();
        idle_a();
        push(0, 0, 0, 64'd0);
        push(0, 1, 0, 64'd0);
        step();

        // Same-address conflict: port 1 wins, in bypass and in storage.
        idle_a();
        wr_en_a = 2'b11;
        wr_addr_a = {AW_A'(3), AW_A'(3)};
        wr_data_a = {32'hBBBB, 32'hAAAA};
        rd_addr_a[0 +: AW_A] = AW_A'(3);
        #1;
        check("conflict bypass x3", 64'(rd_data_a[0 +: DW_A]), 64'hBBBB);
        push(0, 0, 0, 64'hBBBB);
        step();
        idle_a();
        rd_addr_a[0 +: AW_A] = AW_A'(3);
        push(0, 0, 0, 64'hBBBB);
        step();

        // Scoreboard: set, same-cycle release, set-beats-clear, flush-beats-set.
        idle_a();
        bs_en_a = 1'b1;
        bs_addr_a = AW_A'(9);
        rd_addr_a[0 +: AW_A] = AW_A'(9);
        push(0, 1, 0, 64'd0);
        step();
        idle_a();
        rd_addr_a[0 +: AW_A] = AW_A'(9);
        push(0, 1, 0, 64'd1);
        step();
        idle_a();
        wr_en_a = 2'b10;
        wr_addr_a[AW_A +: AW_A] = AW_A'(9);
        wr_data_a[DW_A +: DW_A] = 32'h99;
        rd_addr_a[0 +: AW_A] = AW_A'(9);
        #1;
        check("writeback x9 releases busy", 64'(rd_busy_a[0]), 64'd0);
        push(0, 1, 0, 64'd0);
        push(0, 0, 0, 64'h99);
        step();
        idle_a();
        rd_addr_a[0 +: AW_A] = AW_A'(9);
        push(0, 1, 0, 64'd0);
        step();
        idle_a();
        wr_en_a = 2'b01;
        wr_addr_a[0 +: AW_A] = AW_A'(9);
        wr_data_a[0 +: DW_A] = 32'h77;
        bs_en_a = 1'b1;
        bs_addr_a = AW_A'(9);
        step();
        idle_a();
        rd_addr_a[0 +: AW_A] = AW_A'(9);
        push(0, 1, 0, 64'd1);
        push(0, 0, 0, 64'h77);
        step();
        idle_a();
        flush_a = 1'b1;
        bs_en_a = 1'b1;
        bs_addr_a = AW_A'(4);
        step();
        idle_a();
        rd_addr_a = {AW_A'(9), AW_A'(4)};
        push(0, 1, 0, 64'd0);
        push(0, 1, 1, 64'd0);
        step();

        // Reset asserted mid-run while a write to the same register is in flight.
        idle_a();
        wr_en_a = 2'b01;
        wr_addr_a[0 +: AW_A] = AW_A'(5);
        wr_data_a[0 +: DW_A] = 32'hDEAD_BEEF;
        bs_en_a = 1'b1;
        bs_addr_a = AW_A'(5);
        step();
        idle_a();
        rd_addr_a = {AW_A'(5), AW_A'(5)};
        wr_en_a = 2'b10;
        wr_addr_a[AW_A +: AW_A] = AW_A'(5);
        wr_data_a[DW_A +: DW_A] = 32'h5555;
        rst = 1'b1;
        #1;
        check("reset rd_data x5", 64'(rd_data_a[0 +: DW_A]), 64'd0);
        check("reset rd_busy", 64'(rd_busy_a), 64'd0);
        push(0, 0, 0, 64'd0);
        push(0, 0, 1, 64'd0);
        push(0, 1, 0, 64'd0);
        push(0, 1, 1, 64'd0);
        step();
        rst = 1'b0;
        idle_a();
        rd_addr_a = {AW_A'(5), AW_A'(5)};
        push(0, 0, 0, 64'd0);
        push(0, 1, 1, 64'd0);
        step();

        for (int n = 0; n < RAND_CYCLES; n++) begin
            rand_a();
            step();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-ported integer register file with a per-register busy scoreboard, the next-generation replacement for the single-write, two-read CPU register file. It is clocked, resets asynchronously, and supports configurable data width, depth, read-port count and write-port count. Write-to-read bypass is built in. The scoreboard lets the issue stage detect operands whose producer has not yet written back. The block sits between decode/issue (read ports, busy marking) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; asynchronous and active-high
- wr_en  input  NUM_WR  per-port write enable
- wr_addr  input  NUM_WR*ADDR_W  write addresses, port i in bits [i*ADDR_W +: ADDR_W]
- wr_data  input  NUM_WR*DATA_W  write data, same packing
- rd_addr  input  NUM_RD*ADDR_W  read addresses
- rd_data  output  NUM_RD*DATA_W  read data (combinational, bypassed)
- rd_busy  output  NUM_RD  operand still pending for port i
- busy_set_en  input  1  mark a destination register pending (issue)
- busy_set_addr  input  ADDR_W  register to mark
- flush  input  1  clear every busy bit (pipeline squash)

## Operation
- Register 0 is hardwired to zero: writes to it are discarded, reads return 0, and it is never busy.
- Write: on the rising edge, each port with wr_en=1 and wr_addr≠0 updates its register.
- Same-address conflict: if both write ports target the same register in one cycle, the higher port index wins.
- Read: rd_data[i] is combinational.
  - If any enabled write this cycle targets rd_addr[i] (nonzero), rd_data[i] returns that write's data, highest port index first.
  - Otherwise rd_data[i] returns the stored value.
- Busy bits (one per register), updated on the rising edge:
  - An enabled write to address a clears busy[a].
  - busy_set_en sets busy[busy_set_addr]; set takes priority over a same-cycle clear of the same address (the new producer wins).
  - flush clears all bits and overrides busy_set_en in the same cycle.
  - busy_set_addr=0 is ignored.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (an enabled write to rd_addr[i] this cycle). A writeback therefore releases the operand in the same cycle its data is bypassed.

## Timing
- Reset: all registers 0 and all busy bits 0, applied immediately on rst assertion. All rd_data are then 0 and all rd_busy are 0, independent of clk.
- Reset asserted mid-write: the write is lost and the register reads 0.
- Write-to-read latency: 0 cycles via bypass; the stored value is visible from the edge onward.
- busy_set to rd_busy latency: 1 cycle, i.e. visible after the capturing edge.
- Zero-address writes create no bypass.
- All outputs are purely combinational from state plus the current-cycle write, rd_addr and reset inputs. There are no registered outputs.

## Configuration
- REGFILE_MP_DEBUG_PORT_EN
  - When defined, adds ports dbg_addr (input, ADDR_W) and dbg_data (output, DATA_W). dbg_data is the stored value with no bypass, 0 for address 0, and 0 during reset. This port is used by the test bench and the debug unit.
  - When undefined, both ports are absent and no logic is generated.

## Structure
- Shared package regfile_pkg holds:
  - default constants DATA_W_DEF=32, ADDR_W_DEF=5, NUM_RD_DEF=2, NUM_WR_DEF=2
  - typedef reg_addr_t (logic [ADDR_W_DEF-1:0])
  - typedef reg_data_t (logic [DATA_W_DEF-1:0])
- One sub-module, regfile_scoreboard, owns the busy vector, the set/clear/flush priority, and generation of rd_busy. The top level holds the storage array and the bypass muxes.

## Test plan
- Reset: assert rst mid-run after writing 0xDEADBEEF to x5 → rd_data for x5 is 0 immediately and rd_busy is 0 for all ports.
- Bypass: wr_en[0]=1, wr_addr=7, wr_data=0x1234, rd_addr[1]=7 in the same cycle → rd_data[1]=0x1234 before the edge and after it.
- x0 protection: write 0xFFFFFFFF to address 0 on both ports → rd_data=0, no bypass, busy_set_addr=0 leaves rd_busy=0.
- Write conflict: port0 writes 0xAAAA and port1 writes 0xBBBB to x3 in one cycle → bypass and the stored value are both 0xBBBB.
- Scoreboard:
  - busy_set x9 → next cycle rd_busy=1.
  - Writeback to x9 → rd_busy=0 in that same cycle.
  - busy_set x9 together with a write to x9 → x9 stays busy.
  - flush with busy_set x4 → no bits set.
- Parameter sweep: NUM_RD=4, NUM_WR=1, ADDR_W=4, DATA_W=64 → random write/read traffic matches the reference model over 10k cycles, including dbg_data when REGFILE_MP_DEBUG_PORT_EN is defined.
